gost_result_checker: RTL
========================

Name: gost_result_checker

Overview:
- Consumer end of the unrolled GOST-512 hash pipeline.
- Issues one nonce per cycle towards the pipeline input.
- Realigns each hash emerging LATENCY cycles later with the nonce that produced it, and compares the top 64 hash bits against a target.
- Queues hits (golden nonces) in a small FIFO drained by a valid/ready handshake towards the host/UART side.

Parameters:
- LATENCY, 117, cycles from a nonce_out value being registered to its hash appearing on the hash input; must be >= 1.
- DEPTH, 4, hit FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock for everything.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  pulse; begins a scan, honoured only in IDLE.
- stop  in  1  pulse; ends issuing, honoured only in RUN.
- nonce_base  in  32  first nonce of a scan, sampled on start.
- target  in  64  threshold, sampled on start.
- hash  in  512  pipeline output, one hash per cycle.
- nonce_out  out  32  nonce to splice into pipeline data this cycle.
- running  out  1  high in RUN or DRAIN.
- hit_valid  out  1  FIFO non-empty.
- hit_ready  in  1  consumer accepts the head entry.
- hit_nonce  out  32  head entry nonce.
- hit_hash_hi  out  64  head entry hash[511:448].
- hit_count  out  16  hits since last start; saturates at 0xFFFF; includes dropped hits.
- overflow  out  1  sticky; a hit was dropped because the FIFO was full.

Behaviour:
- Reset value of every output is 0: nonce_out, running, hit_valid, hit_nonce, hit_hash_hi, hit_count, overflow. State is IDLE, FIFO empty, age=0, inflight=0, chk_nonce=0.
- IDLE to RUN on start:
  - nonce_out and chk_nonce load nonce_base; target is latched; age, inflight, hit_count and overflow clear.
  - The FIFO is not flushed.
  - start and stop in the same IDLE cycle: start wins.
- RUN:
  - Each cycle, nonce_out increments (mod 2^32, wrapping 0xFFFFFFFF to 0). This counts as one issue.
  - age increments, saturating at LATENCY.
  - check_en = (age == LATENCY) && (inflight != 0).
- Check, when check_en is set:
  - hit = hash[511:448] <= latched target, unsigned.
  - chk_nonce increments (mod 2^32). This counts as one check.
  - Hashes arriving while check_en is low are ignored.
- inflight tracking:
  - inflight += issue - check; width clog2(LATENCY+2).
  - In steady RUN, issue and check occur together, so inflight holds at LATENCY.
- RUN to DRAIN on stop:
  - nonce_out freezes and issuing stops.
  - age keeps saturating-counting; checks continue.
- DRAIN to IDLE in the cycle after inflight reaches 0; running falls with the state change.
  - start during DRAIN is ignored.
  - A stop arriving before age reaches LATENCY still drains all issued nonces.
- On a hit:
  - Push {chk_nonce, hash[511:448]} if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise drop the entry and set overflow.
  - hit_count increments on every hit, saturating.
- FIFO:
  - First-word-fall-through; hit_nonce/hit_hash_hi present the head entry. Pop on hit_valid && hit_ready.
  - When empty, the head outputs hold their last value (0 after reset); consumers must qualify them with hit_valid.
  - Push/pop latency: an entry pushed at edge t is visible with hit_valid=1 after edge t.
- Reset mid-scan: immediate return to IDLE, all outputs 0, FIFO contents lost.

Decomposition:
- Package gost_pkg:
  - NONCE_W=32, HASH_W=512, TGT_W=64.
  - State enum {IDLE, RUN, DRAIN}.
  - Packed hit_t {nonce, hash_hi}.
- Sub-module gost_hit_fifo:
  - Ports: clk, reset, push, push_data (hit_t), pop, full, empty, head.
  - Parameter DEPTH.
  - Read/write pointers with an extra wrap bit.

Test Plan (bench uses LATENCY=4, DEPTH=4 and a model pipeline delaying nonce_out by 4 cycles into hash[511:448] = f(nonce)):
- reset asserted mid-RUN with 2 FIFO entries -> all outputs 0 on the same cycle (asynchronous), state IDLE, hit_valid 0.
- start, nonce_base=0x100, target=0x10, model hash_hi = 0x20 except nonce 0x105 -> 0x0F; stop after 12 cycles -> exactly one hit, nonce 0x105, hash_hi 0x0F, hit_count 1; running drops after the drain of 4 checks.
- nonce_base=0xFFFFFFFE, hash_hi=0 (all hits), hit_ready=1, stop after 4 issues -> hits 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 in order; hit_count 4; overflow 0.
- All hits, hit_ready=0, run 10 checks -> FIFO holds the first 4 nonces, overflow=1, hit_count=10; then raise hit_ready -> 4 pops in order, then hit_valid=0.
- FIFO full plus a simultaneous pop and hit -> push accepted, overflow stays 0, occupancy stays 4.
- stop one cycle after start (1 nonce issued, age<LATENCY) -> DRAIN waits, checks exactly 1 hash at age==4, then IDLE; start pulsed during DRAIN is ignored.

Source files
------------

// File: rtl/gost_pkg.sv
// Shared widths, scan FSM states and the hit record for the GOST-512 result checker.
package gost_pkg;

  localparam int NONCE_W = 32;
  localparam int HASH_W  = 512;
  localparam int TGT_W   = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [NONCE_W-1:0] nonce;
    logic [TGT_W-1:0]   hash_hi;
  } hit_t;

endpackage

// File: rtl/gost_hit_fifo.sv
// First-word-fall-through hit queue; a push at edge t is visible at head after edge t.
// head is registered so it keeps its last value when the queue drains empty.
module gost_hit_fifo
  import gost_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  hit_t push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output hit_t head
);

  localparam int AW = $clog2(DEPTH);

  hit_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] rd_next;
  logic          do_pop;
  logic          do_push;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_next = rd_ptr[AW-1:0] + AW'(1);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // Head follows the entry behind the popped one, or the incoming push if that is all there is.
      if (do_pop) begin
        if (count != (AW+1)'(1)) head <= mem[rd_next];
        else if (do_push)        head <= push_data;
      end else if (do_push && empty) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/gost_result_checker.sv
// Issues nonces into the GOST-512 pipeline, realigns hashes LATENCY cycles later and queues
// hits (hash_hi <= target) in a valid/ready FIFO; full FIFO drops the hit and sets overflow.
module gost_result_checker
  import gost_pkg::*;
#(
  parameter int LATENCY = 117,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [TGT_W-1:0]   target,
  input  logic [HASH_W-1:0]  hash,
  output logic [NONCE_W-1:0] nonce_out,
  output logic               running,
  output logic               hit_valid,
  input  logic               hit_ready,
  output logic [NONCE_W-1:0] hit_nonce,
  output logic [TGT_W-1:0]   hit_hash_hi,
  output logic [15:0]        hit_count,
  output logic               overflow
);

  localparam int AGE_W = $clog2(LATENCY + 1);
  localparam int INF_W = $clog2(LATENCY + 2);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY);

  state_t             state;
  state_t             state_nxt;
  logic [AGE_W-1:0]   age;
  logic [INF_W-1:0]   inflight;
  logic [NONCE_W-1:0] chk_nonce;
  logic [TGT_W-1:0]   tgt;
  logic [TGT_W-1:0]   hash_hi;
  logic               issue;
  logic               check_en;
  logic               hit;
  logic               pop;
  logic               push_ok;
  logic               fifo_full;
  logic               fifo_empty;
  hit_t               head;
  logic               unused_hash_lo;

  assign hash_hi        = hash[HASH_W-1 -: TGT_W];
  assign unused_hash_lo = ^hash[HASH_W-TGT_W-1:0];

  // The nonce presented during a RUN cycle enters the pipeline, including the stop cycle.
  assign issue    = (state == RUN);
  assign check_en = (state != IDLE) && (age == AGE_MAX) && (inflight != '0);
  assign hit      = check_en && (hash_hi <= tgt);
  assign pop      = hit_valid && hit_ready;
  assign push_ok  = !fifo_full || pop;

  assign running     = (state != IDLE);
  assign hit_valid   = !fifo_empty;
  assign hit_nonce   = head.nonce;
  assign hit_hash_hi = head.hash_hi;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (stop) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      nonce_out <= '0;
      chk_nonce <= '0;
      tgt       <= '0;
      age       <= '0;
      inflight  <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        nonce_out <= nonce_base;
        chk_nonce <= nonce_base;
        tgt       <= target;
        age       <= '0;
        inflight  <= '0;
        hit_count <= '0;
        overflow  <= 1'b0;
      end else begin
        if (state == RUN && !stop) nonce_out <= nonce_out + 1'b1;
        if (state != IDLE && age != AGE_MAX) age <= age + 1'b1;
        inflight <= inflight + INF_W'(issue) - INF_W'(check_en);
        if (check_en) chk_nonce <= chk_nonce + 1'b1;
        if (hit) begin
          if (hit_count != 16'hFFFF) hit_count <= hit_count + 1'b1;
          if (!push_ok) overflow <= 1'b1;
        end
      end
    end
  end

  gost_hit_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (hit && push_ok),
    .push_data ('{nonce: chk_nonce, hash_hi: hash_hi}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

endmodule
